bram_access_unit: RTL and testbench

//  Request/response front end for the single-port byte-enable block RAM.
//  - Takes byte-addressed load/store requests (byte/half/word/dword) on a valid/ready port.
//  - Drives the RAM's ADDR/DI/WE/RE/BE ports directly and tracks the RAM's 1-cycle read latency.
//  - Returns aligned, sign- or zero-extended load data and store acks on a valid/ready response port.

---
 rtl/bram_access_unit.sv | 185 ++++++++++++++++++
 tb/tb_bram_access_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_access_unit.sv
// bram_access_unit: valid/ready request front end for a single-port,
// byte-enable block RAM with one cycle of read latency. Accepted
// requests drive the RAM in the same cycle. A PEND stage tracks the
// access in flight, and a RESP register holds the response.
module bram_access_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                                    CLK,
  input  logic                                    RST_N,
  input  logic                                    REQ_VALID,
  output logic                                    REQ_READY,
  input  logic                                    REQ_WRITE,
  input  logic [ADDR_WIDTH-1:0]                   REQ_ADDR,
  input  logic [1:0]                              REQ_SIZE,
  input  logic                                    REQ_SIGNED,
  input  logic [DATA_WIDTH-1:0]                   REQ_DATA,
  output logic                                    RESP_VALID,
  input  logic                                    RESP_READY,
  output logic [DATA_WIDTH-1:0]                   RESP_DATA,
  output logic                                    RESP_ERR,
  output logic [ADDR_WIDTH-$clog2(BE_WIDTH)-1:0]  RAM_ADDR,
  output logic [DATA_WIDTH-1:0]                   RAM_DI,
  output logic                                    RAM_WE,
  output logic                                    RAM_RE,
  output logic [BE_WIDTH-1:0]                     RAM_BE,
  input  logic [DATA_WIDTH-1:0]                   RAM_DO
);

  localparam int OFF_W = $clog2(BE_WIDTH);

  // Request decode
  logic [OFF_W-1:0]       req_off;
  logic [3:0]             req_bytes;
  logic                   req_err;
  logic                   req_ready;
  logic                   fire;
  logic                   ram_we;
  logic                   ram_re;
  logic [BE_WIDTH-1:0]    ram_be;
  logic [DATA_WIDTH-1:0]  ram_di;

  // PEND stage: the access whose RAM read data arrives this cycle
  logic                   pend_valid_q, pend_valid_d;
  logic                   pend_write_q, pend_write_d;
  logic                   pend_err_q, pend_err_d;
  logic [OFF_W-1:0]       pend_off_q, pend_off_d;
  logic [1:0]             pend_size_q, pend_size_d;
  logic                   pend_signed_q, pend_signed_d;
  logic                   advance;

  // Load formatting
  logic [DATA_WIDTH-1:0]  shifted;
  logic [7:0]             nbits;
  logic                   fill;
  logic [DATA_WIDTH-1:0]  load_data;

  // RESP register
  logic                   resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]  resp_data_q, resp_data_d;
  logic                   resp_err_q, resp_err_d;

  // Decode the incoming request: lane offset, access size and legality
  always_comb begin
    req_off   = REQ_ADDR[OFF_W-1:0];
    req_bytes = 4'd1 << REQ_SIZE;
    req_err   = ((REQ_SIZE == 2'd3) && (DATA_WIDTH == 32)) ||
                ((4'(req_off) & (req_bytes - 4'd1)) != 4'd0);
  end

  // Handshake: PEND may refill whenever its content moves to RESP this cycle
  always_comb begin
    advance   = pend_valid_q & (~resp_valid_q | RESP_READY);
    req_ready = RST_N & (~pend_valid_q | ~resp_valid_q | RESP_READY);
    fire      = REQ_VALID & req_ready;
    ram_re    = fire & ~REQ_WRITE & ~req_err;
    ram_we    = fire &  REQ_WRITE & ~req_err;
  end

  // Store lanes: enable the addressed bytes, replicate the data across all lanes
  always_comb begin
    ram_be = '0;
    ram_di = '0;
    for (int unsigned i = 0; i < BE_WIDTH; i++) begin
      ram_be[i]       = ram_we & (i >= 32'(req_off)) &
                        (i < 32'(req_off) + 32'(req_bytes));
      ram_di[i*8 +: 8] = REQ_DATA[8*(i % 32'(req_bytes)) +: 8];
    end
  end

  // Drive the RAM ports straight from the accepted request
  always_comb begin
    RAM_ADDR  = REQ_ADDR[ADDR_WIDTH-1:OFF_W];
    RAM_DI    = ram_di;
    RAM_WE    = ram_we;
    RAM_RE    = ram_re;
    RAM_BE    = ram_be;
    REQ_READY = req_ready;
  end

  // PEND next state: load on accept, empty when handed to RESP, else hold
  always_comb begin
    pend_valid_d  = pend_valid_q;
    pend_write_d  = pend_write_q;
    pend_err_d    = pend_err_q;
    pend_off_d    = pend_off_q;
    pend_size_d   = pend_size_q;
    pend_signed_d = pend_signed_q;
    if (advance) begin
      pend_valid_d = 1'b0;
    end
    if (fire) begin
      pend_valid_d  = 1'b1;
      pend_write_d  = REQ_WRITE;
      pend_err_d    = req_err;
      pend_off_d    = req_off;
      pend_size_d   = REQ_SIZE;
      pend_signed_d = REQ_SIGNED;
    end
  end

  // Align RAM_DO to the addressed bytes, then sign- or zero-extend past the access width
  always_comb begin
    shifted = RAM_DO >> {pend_off_q, 3'b000};
    nbits   = 8'd8 << pend_size_q;
    if (32'(nbits) > DATA_WIDTH) begin
      nbits = 8'(DATA_WIDTH);
    end
    fill      = pend_signed_q & shifted[nbits - 8'd1];
    load_data = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      load_data[i] = (i < 32'(nbits)) ? shifted[i] : fill;
    end
  end

  // RESP next state: capture PEND when it advances, drop after a handshake
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    if (advance) begin
      resp_valid_d = 1'b1;
      resp_err_d   = pend_err_q;
      resp_data_d  = (pend_write_q | pend_err_q) ? '0 : load_data;
    end else if (RESP_READY) begin
      resp_valid_d = 1'b0;
      resp_data_d  = '0;
      resp_err_d   = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_valid_q  <= 1'b0;
      pend_write_q  <= 1'b0;
      pend_err_q    <= 1'b0;
      pend_off_q    <= '0;
      pend_size_q   <= '0;
      pend_signed_q <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      pend_valid_q  <= pend_valid_d;
      pend_write_q  <= pend_write_d;
      pend_err_q    <= pend_err_d;
      pend_off_q    <= pend_off_d;
      pend_size_q   <= pend_size_d;
      pend_signed_q <= pend_signed_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      resp_err_q    <= resp_err_d;
    end
  end

  // Response port outputs
  always_comb begin
    RESP_VALID = resp_valid_q;
    RESP_DATA  = resp_data_q;
    RESP_ERR   = resp_err_q;
  end

endmodule

// File: tb/tb_bram_access_unit.sv
// Testbench for bram_access_unit (32-bit RAM): directed vector table,
// stall/reset sequences and random traffic against a byte-array model.
module tb_bram_access_unit;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          REQ_VALID = 1'b0;
  logic          REQ_READY;
  logic          REQ_WRITE = 1'b0;
  logic [AW-1:0] REQ_ADDR = '0;
  logic [1:0]    REQ_SIZE = '0;
  logic          REQ_SIGNED = 1'b0;
  logic [DW-1:0] REQ_DATA = '0;
  logic          RESP_VALID;
  logic          RESP_READY = 1'b1;
  logic [DW-1:0] RESP_DATA;
  logic          RESP_ERR;
  logic [13:0]   RAM_ADDR;
  logic [DW-1:0] RAM_DI;
  logic          RAM_WE;
  logic          RAM_RE;
  logic [3:0]    RAM_BE;
  logic [DW-1:0] RAM_DO;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  bram_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_SIZE(REQ_SIZE), .REQ_SIGNED(REQ_SIGNED),
    .REQ_DATA(REQ_DATA), .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY),
    .RESP_DATA(RESP_DATA), .RESP_ERR(RESP_ERR), .RAM_ADDR(RAM_ADDR),
    .RAM_DI(RAM_DI), .RAM_WE(RAM_WE), .RAM_RE(RAM_RE), .RAM_BE(RAM_BE),
    .RAM_DO(RAM_DO)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Simple RAM: 1-cycle read, DO held while RE low
  logic [31:0] tb_mem [0:63];
  logic [31:0] ram_do_q;
  logic        mem_clr = 1'b1;
  assign RAM_DO = ram_do_q;

  always @(posedge CLK) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= '0;
    end else if (RAM_WE) begin
      for (int b = 0; b < 4; b++)
        if (RAM_BE[b]) tb_mem[RAM_ADDR[5:0]][b*8 +: 8] <= RAM_DI[b*8 +: 8];
    end
    if (RAM_RE) ram_do_q <= tb_mem[RAM_ADDR[5:0]];
  end

  // Reference model: byte-addressed memory plus in-order expected-response queue
  typedef struct { logic [31:0] data; logic err; } exp_t;
  logic [7:0] ref_mem [0:255];
  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_acc = 0;
  int         n_resp = 0;
  int         overlap = 0;

  function automatic exp_t model_req(logic wr, logic [15:0] a, logic [1:0] sz,
                                     logic sg, logic [31:0] d);
    exp_t r;
    int unsigned nb;
    logic [31:0] v;
    nb     = 32'd1 << sz;
    v      = '0;
    r.data = '0;
    r.err  = (sz == 2'd3) || ((32'(a) % nb) != 0);
    if (!r.err) begin
      if (wr) begin
        for (int unsigned i = 0; i < nb; i++) ref_mem[(32'(a) + i) & 255] = d[8*i +: 8];
      end else begin
        for (int unsigned i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[(32'(a) + i) & 255];
        if (sg && v[8*nb-1])
          for (int unsigned k = 8*nb; k < 32; k++) v[k] = 1'b1;
        r.data = v;
      end
    end
    return r;
  endfunction

  always @(negedge CLK) begin
    if (mem_clr) for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    if (!RST_N) begin
      exp_q.delete();
      n_acc  = 0;
      n_resp = 0;
    end else begin
      if (RAM_RE && RAM_WE) overlap++;
      if (RESP_VALID && RESP_READY) begin
        n_resp++;
        if (exp_q.size() == 0) check("resp_unexpected", 64'(RESP_VALID), 64'(0));
        else begin
          mon_e = exp_q.pop_front();
          check("sb_data", 64'(RESP_DATA), 64'(mon_e.data));
          check("sb_err", 64'(RESP_ERR), 64'(mon_e.err));
        end
      end
      if (REQ_VALID && REQ_READY) begin
        n_acc++;
        exp_q.push_back(model_req(REQ_WRITE, REQ_ADDR, REQ_SIZE, REQ_SIGNED, REQ_DATA));
      end
    end
  end

  // Directed vector table
  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_di;
  } vec_t;

  vec_t vecs[15];

  task automatic run_vec(input vec_t v);
    REQ_VALID = 1'b1; REQ_WRITE = v.wr; REQ_ADDR = v.addr;
    REQ_SIZE = v.size; REQ_SIGNED = v.sgn; REQ_DATA = v.data;
    @(negedge CLK);
    check("tbl_accept", 64'(REQ_READY), 64'(1));
    check("tbl_ram_re", 64'(RAM_RE), 64'(!v.wr && !v.exp_err));
    check("tbl_ram_we", 64'(RAM_WE), 64'(v.wr && !v.exp_err));
    check("tbl_ram_be", 64'(RAM_BE), 64'(v.exp_be));
    if (v.wr && !v.exp_err) check("tbl_ram_di", 64'(RAM_DI), 64'(v.exp_di));
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    @(negedge CLK);
    check("tbl_lat1_valid", 64'(RESP_VALID), 64'(0));
    @(negedge CLK);
    check("tbl_lat2_valid", 64'(RESP_VALID), 64'(1));
    check("tbl_data", 64'(RESP_DATA), 64'(v.exp_data));
    check("tbl_err", 64'(RESP_ERR), 64'(v.exp_err));
    @(posedge CLK); #1;
  endtask

  task automatic send(input logic wr, input logic [15:0] a, input logic [1:0] sz,
                      input logic sg, input logic [31:0] d);
    bit done;
    done = 0;
    REQ_VALID = 1'b1; REQ_WRITE = wr; REQ_ADDR = a;
    REQ_SIZE = sz; REQ_SIGNED = sg; REQ_DATA = d;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge CLK);
      done = REQ_READY;
      @(posedge CLK); #1;
    end
    REQ_VALID = 1'b0;
    if (!done) check("send_timeout", 64'(done), 64'(1));
  endtask

  task automatic drain(input string name);
    RESP_READY = 1'b1;
    REQ_VALID  = 1'b0;
    for (int i = 0; i < 30 && (exp_q.size() != 0 || RESP_VALID); i++) @(negedge CLK);
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
    check({name, "_resp_count"}, 64'(n_resp), 64'(n_acc));
    @(posedge CLK); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bit fired;
    int seen;

    vecs[0]  = '{1'b1, 16'h10, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 4'b1111, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 16'h10, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 4'b0000, 32'h0};
    vecs[2]  = '{1'b1, 16'h13, 2'd0, 1'b0, 32'h00000080, 32'h0,        1'b0, 4'b1000, 32'h80808080};
    vecs[3]  = '{1'b0, 16'h13, 2'd0, 1'b1, 32'h0,        32'hFFFFFF80, 1'b0, 4'b0000, 32'h0};
    vecs[4]  = '{1'b0, 16'h13, 2'd0, 1'b0, 32'h0,        32'h00000080, 1'b0, 4'b0000, 32'h0};
    vecs[5]  = '{1'b0, 16'h11, 2'd1, 1'b0, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0};
    vecs[6]  = '{1'b0, 16'h10, 2'd3, 1'b0, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0};
    vecs[7]  = '{1'b1, 16'h16, 2'd1, 1'b0, 32'hABCD1234, 32'h0,        1'b0, 4'b1100, 32'h12341234};
    vecs[8]  = '{1'b0, 16'h16, 2'd1, 1'b1, 32'h0,        32'h00001234, 1'b0, 4'b0000, 32'h0};
    vecs[9]  = '{1'b0, 16'h14, 2'd2, 1'b0, 32'h0,        32'h12340000, 1'b0, 4'b0000, 32'h0};
    vecs[10] = '{1'b0, 16'h12, 2'd1, 1'b1, 32'h0,        32'hFFFF80AD, 1'b0, 4'b0000, 32'h0};
    vecs[11] = '{1'b1, 16'h11, 2'd2, 1'b0, 32'h55555555, 32'h0,        1'b1, 4'b0000, 32'h0};
    vecs[12] = '{1'b0, 16'h11, 2'd0, 1'b0, 32'h0,        32'h000000BE, 1'b0, 4'b0000, 32'h0};
    vecs[13] = '{1'b1, 16'h12, 2'd1, 1'b0, 32'h0000F00D, 32'h0,        1'b0, 4'b1100, 32'hF00DF00D};
    vecs[14] = '{1'b0, 16'h12, 2'd0, 1'b1, 32'h0,        32'h0000000D, 1'b0, 4'b0000, 32'h0};

    // Reset state, with a request already presented
    REQ_VALID = 1'b1;
    #3;
    check("rst_req_ready", 64'(REQ_READY), 64'(0));
    check("rst_resp_valid", 64'(RESP_VALID), 64'(0));
    check("rst_resp_data", 64'(RESP_DATA), 64'(0));
    check("rst_resp_err", 64'(RESP_ERR), 64'(0));
    check("rst_ram_re", 64'(RAM_RE), 64'(0));
    check("rst_ram_we", 64'(RAM_WE), 64'(0));
    REQ_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    mem_clr = 1'b0;
    RST_N   = 1'b1;
    @(posedge CLK); #1;

    foreach (vecs[i]) run_vec(vecs[i]);
    drain("table");

    // Stall: three back-to-back loads with RESP_READY low for 4 cycles
    send(1'b1, 16'h00, 2'd2, 1'b0, 32'h11111111);
    send(1'b1, 16'h04, 2'd2, 1'b0, 32'h22222222);
    send(1'b1, 16'h08, 2'd2, 1'b0, 32'h33333333);
    drain("stall_prep");
    RESP_READY = 1'b0;
    REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_ADDR = 16'h00; REQ_SIZE = 2'd2; REQ_SIGNED = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 12 && acc < 3; cyc++) begin
      @(negedge CLK);
      if (cyc == 2 || cyc == 3) begin
        check("stall_req_ready", 64'(REQ_READY), 64'(0));
        check("stall_ram_re", 64'(RAM_RE), 64'(0));
        check("stall_resp_valid", 64'(RESP_VALID), 64'(1));
        check("stall_resp_hold", 64'(RESP_DATA), 64'(32'h11111111));
      end
      if (cyc == 4) check("stall_release_ready", 64'(REQ_READY), 64'(1));
      fired = REQ_READY;
      @(posedge CLK); #1;
      if (fired) begin
        acc++;
        REQ_ADDR = 16'(acc * 4);
        if (acc == 3) REQ_VALID = 1'b0;
      end
      if (cyc == 3) RESP_READY = 1'b1;
    end
    check("stall_accepts", 64'(acc), 64'(3));
    drain("stall");

    // Reset while a load is in PEND; the store before it is already committed
    send(1'b1, 16'h20, 2'd2, 1'b0, 32'hCAFEF00D);
    REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_ADDR = 16'h24; REQ_SIZE = 2'd2;
    @(negedge CLK);
    check("rstmid_accept", 64'(REQ_READY), 64'(1));
    @(posedge CLK); #2;
    RST_N = 1'b0;
    #1;
    check("rstmid_resp_valid", 64'(RESP_VALID), 64'(0));
    check("rstmid_req_ready", 64'(REQ_READY), 64'(0));
    check("rstmid_ram_re", 64'(RAM_RE), 64'(0));
    check("rstmid_resp_data", 64'(RESP_DATA), 64'(0));
    REQ_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (RESP_VALID) seen++;
    end
    check("rstmid_no_stale", 64'(seen), 64'(0));
    check("rstmid_ready_after", 64'(REQ_READY), 64'(1));
    @(posedge CLK); #1;
    send(1'b0, 16'h20, 2'd2, 1'b0, 32'h0);
    drain("rstmid");

    // Random mixed traffic with random RESP_READY
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge CLK);
      fired = REQ_VALID && REQ_READY;
      @(posedge CLK); #1;
      RESP_READY = ($urandom_range(0, 9) < 6);
      if (!REQ_VALID || fired) begin
        REQ_VALID  = ($urandom_range(0, 9) < 7);
        REQ_WRITE  = $urandom_range(0, 1) == 1;
        REQ_SIZE   = 2'($urandom_range(0, 3));
        REQ_SIGNED = $urandom_range(0, 1) == 1;
        REQ_DATA   = $urandom;
        REQ_ADDR   = 16'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0)
          REQ_ADDR = REQ_ADDR & ~(16'((32'd1 << REQ_SIZE) - 1));
      end
    end
    drain("random");
    check("re_we_exclusive", 64'(overlap), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
